// File: rtl/master_slave_jk_ff.sv
// Master-slave JK flip-flop: the master captures the JK function on the rising
// edge and the slave copies the master on the falling edge. Both stages are visible.
module master_slave_jk_ff (
  input  logic clock,
  input  logic reset,
  input  logic x,
  input  logic y,
  input  logic pi,
  input  logic ci,
  input  logic a1,
  input  logic b1,
  input  logic a2,
  input  logic b2,
  output logic a3,
  output logic b3,
  output logic a4,
  output logic b4
);

  // Power-up value before any reset is zero for both stages.
  logic r_m = 1'b0;
  logic r_s = 1'b0;

  logic w_m_seed;
  logic w_s_seed;
  logic w_jk_next;

  // A seed pair is only meaningful when its two rails disagree; otherwise load 0.
  assign w_m_seed = (a1 != b1) ? a1 : 1'b0;
  assign w_s_seed = (a2 != b2) ? a2 : 1'b0;

  // Feedback comes from the slave, so J=K=1 toggles once per period.
  always_comb begin
    w_jk_next = r_s;
    case ({x, y})
      2'b00:   w_jk_next = r_s;
      2'b10:   w_jk_next = 1'b1;
      2'b01:   w_jk_next = 1'b0;
      default: w_jk_next = ~r_s;
    endcase
  end

  // NOTE: non-blocking assignments keep both stages sampling pre-edge values.
  always_ff @(posedge clock) begin
    if (reset)    r_m <= w_m_seed;
    else if (!ci) r_m <= 1'b0;
    else if (!pi) r_m <= 1'b1;
    else          r_m <= w_jk_next;
  end

  always_ff @(negedge clock) begin
    if (reset) r_s <= w_s_seed;
    else       r_s <= r_m;
  end

  assign a3 = r_m;
  assign b3 = ~r_m;
  assign a4 = r_s;
  assign b4 = ~r_s;

endmodule

// File: tb/tb_master_slave_jk_ff.sv
// Directed, table-driven bench for master_slave_jk_ff: every vector is one clock
// period with hand-computed master/slave results after the rise and the fall.
module tb_master_slave_jk_ff;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic x = 1'b0, y = 1'b0, pi = 1'b1, ci = 1'b1;
  logic a1 = 1'b0, b1 = 1'b0, a2 = 1'b0, b2 = 1'b0;
  logic a3, b3, a4, b4;

  int n_vec = 0;
  int n_err = 0;

  master_slave_jk_ff dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .pi(pi), .ci(ci),
    .a1(a1), .b1(b1), .a2(a2), .b2(b2),
    .a3(a3), .b3(b3), .a4(a4), .b4(b4)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic       rst_rise;
    logic       rst_fall;
    logic [1:0] xy;
    logic [1:0] pc;     // {pi, ci}
    logic [1:0] seed1;  // {a1, b1}
    logic [1:0] seed2;  // {a2, b2}
    logic       exp_m;
    logic       exp_s;
  } vec_t;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  vec_t vecs[$];
  logic prev_s;

  initial begin
    vecs = '{
      '{"rst_invalid_seeds", 1, 1, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0},
      '{"rst_rise_only",     1, 0, 2'b00, 2'b11, 2'b10, 2'b01, 1, 1},
      '{"rst_both_edges",    1, 1, 2'b00, 2'b11, 2'b10, 2'b01, 1, 0},
      '{"rst_m11_s10",       1, 1, 2'b00, 2'b11, 2'b11, 2'b10, 0, 1},
      '{"rst_m01_s00",       1, 1, 2'b00, 2'b11, 2'b01, 2'b00, 0, 0},
      '{"preset_j",          0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 1, 1},
      '{"clear_k",           0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0},
      '{"set_j",             0, 0, 2'b10, 2'b11, 2'b00, 2'b00, 1, 1},
      '{"toggle_1",          0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0},
      '{"toggle_2",          0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 1, 1},
      '{"toggle_3",          0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0},
      '{"toggle_4",          0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 1, 1},
      '{"clear_beats_preset",0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0},
      '{"hold_0",            0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0},
      '{"set_again",         0, 0, 2'b10, 2'b11, 2'b00, 2'b00, 1, 1},
      '{"hold_1",            0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 1, 1},
      '{"preset_beats_k",    0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 1, 1},
      '{"reset_k",           0, 0, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0},
      '{"clear_beats_j",     0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0},
      '{"set_before_rst",    0, 0, 2'b10, 2'b11, 2'b00, 2'b00, 1, 1},
      '{"rst_beats_preset",  1, 0, 2'b10, 2'b01, 2'b01, 2'b00, 0, 0},
      '{"rst_slave_only",    0, 1, 2'b10, 2'b11, 2'b00, 2'b00, 1, 0},
      '{"toggle_uses_s",     0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 1, 1},
      '{"hold_after_toggle", 0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 1, 1}
    };

    // Power-up state before any clock edge.
    #1;
    check("powerup_master", {a3, b3}, 2'b01);
    check("powerup_slave",  {a4, b4}, 2'b01);

    prev_s = 1'b0;
    foreach (vecs[i]) begin
      reset    = vecs[i].rst_rise;
      {x, y}   = vecs[i].xy;
      {pi, ci} = vecs[i].pc;
      {a1, b1} = vecs[i].seed1;
      {a2, b2} = vecs[i].seed2;
      @(posedge clock);
      #1;
      check({vecs[i].name, "_master"}, {a3, b3}, {vecs[i].exp_m, ~vecs[i].exp_m});
      check({vecs[i].name, "_slave_at_rise"}, {a4, b4}, {prev_s, ~prev_s});
      reset = vecs[i].rst_fall;
      @(negedge clock);
      #1;
      check({vecs[i].name, "_slave"}, {a4, b4}, {vecs[i].exp_s, ~vecs[i].exp_s});
      prev_s = vecs[i].exp_s;
    end

    // Inputs changed between rise and fall must not reach either stage until the next rise.
    reset = 0; x = 0; y = 1; pi = 1; ci = 1;
    @(posedge clock);
    #1;
    check("late_change_master_k", {a3, b3}, 2'b01);
    x = 1; y = 0; pi = 0;
    #2;
    check("late_change_master_hold", {a3, b3}, 2'b01);
    @(negedge clock);
    #1;
    check("late_change_slave", {a4, b4}, 2'b01);
    @(posedge clock);
    #1;
    check("late_change_taken", {a3, b3}, 2'b10);
    check("late_change_slave_at_rise", {a4, b4}, 2'b01);
    @(negedge clock);
    #1;
    check("late_change_slave_follow", {a4, b4}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
